// File: rtl/bpd_update_scheduler.sv
// Merges redirect/repair updates (priority) with a buffered commit-update stream into one
// registered ready/valid predictor update port, with a starvation bound that guarantees commits make progress.
module bpd_update_scheduler #(
  parameter int PAYLOAD_W    = 400,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_redirect_valid,
  output logic                 io_redirect_ready,
  input  logic [PAYLOAD_W-1:0] io_redirect_bits,
  input  logic                 io_commit_valid,
  output logic                 io_commit_ready,
  input  logic [PAYLOAD_W-1:0] io_commit_bits,
  input  logic                 io_commit_flush,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [PAYLOAD_W-1:0] io_out_bits,
  output logic                 io_out_is_commit
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PAYLOAD_W-1:0] mem_q [QDEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_commit_q, out_commit_d;
  logic [PAYLOAD_W-1:0] out_bits_q, out_bits_d;

  logic empty, full, load_en, force_commit;
  logic grant_redirect, commit_sel, enq, deq;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(QDEPTH));
  assign load_en      = !out_valid_q || io_out_ready;
  assign force_commit = (starve_q == SW'(STARVE_LIMIT)) && !empty;

  assign io_commit_ready   = !full && !io_commit_flush;
  assign io_redirect_ready = load_en && !force_commit;

  assign grant_redirect = io_redirect_ready && io_redirect_valid;
  assign commit_sel     = load_en && (force_commit || (!io_redirect_valid && !empty));
  // A flush hides the queue from the output mux as well as from the pointers.
  assign deq            = commit_sel && !io_commit_flush;
  assign enq            = io_commit_valid && io_commit_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_d     = starve_q;
    out_valid_d  = out_valid_q;
    out_commit_d = out_commit_q;
    out_bits_d   = out_bits_q;

    if (io_commit_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      starve_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
      if (deq || empty)
        starve_d = '0;
      else if (grant_redirect && (starve_q != SW'(STARVE_LIMIT)))
        starve_d = starve_q + SW'(1);
    end

    if (load_en) begin
      if (grant_redirect) begin
        out_valid_d  = 1'b1;
        out_bits_d   = io_redirect_bits;
        out_commit_d = 1'b0;
      end else if (deq) begin
        out_valid_d  = 1'b1;
        out_bits_d   = mem_q[rd_ptr_q];
        out_commit_d = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      out_valid_q  <= 1'b0;
      out_commit_q <= 1'b0;
      out_bits_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      out_valid_q  <= out_valid_d;
      out_commit_q <= out_commit_d;
      out_bits_q   <= out_bits_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in count_q.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= io_commit_bits;
  end

  assign io_out_valid     = out_valid_q;
  assign io_out_bits      = out_bits_q;
  assign io_out_is_commit = out_commit_q;
endmodule

// File: tb/tb_bpd_update_scheduler.sv
// Directed bench for bpd_update_scheduler: redirect stream, commit latency, starvation,
// backpressure/full, flush and asynchronous reset, with hand-computed expectations.
module tb_bpd_update_scheduler;
  localparam int PW = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_redirect_valid = 1'b0;
  logic          io_redirect_ready;
  logic [PW-1:0] io_redirect_bits = '0;
  logic          io_commit_valid = 1'b0;
  logic          io_commit_ready;
  logic [PW-1:0] io_commit_bits = '0;
  logic          io_commit_flush = 1'b0;
  logic          io_out_valid;
  logic          io_out_ready = 1'b0;
  logic [PW-1:0] io_out_bits;
  logic          io_out_is_commit;

  int tests = 0;
  int fails = 0;
  int accepted;

  bpd_update_scheduler #(.PAYLOAD_W(PW), .QDEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .io_redirect_valid(io_redirect_valid), .io_redirect_ready(io_redirect_ready),
    .io_redirect_bits(io_redirect_bits),
    .io_commit_valid(io_commit_valid), .io_commit_ready(io_commit_ready),
    .io_commit_bits(io_commit_bits), .io_commit_flush(io_commit_flush),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits(io_out_bits), .io_out_is_commit(io_out_is_commit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PW-1:0] pl(input logic [31:0] v);
    return PW'(v);
  endfunction

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_out_valid", PW'(io_out_valid), pl(0));
    chk("rst_out_bits", io_out_bits, pl(0));
    chk("rst_is_commit", PW'(io_out_is_commit), pl(0));
    chk("rst_commit_ready", PW'(io_commit_ready), pl(1));
    chk("rst_redirect_ready", PW'(io_redirect_ready), pl(1));
    #10 reset = 1'b0;
    tick();

    // Redirect only: A, B, C with 1-cycle latency
    io_out_ready = 1'b1;
    io_redirect_valid = 1'b1;
    io_redirect_bits = pl(32'hA);
    #1 chk("redir_ready", PW'(io_redirect_ready), pl(1));
    tick();
    chk("redir_A", io_out_bits, pl(32'hA));
    chk("redir_A_valid", PW'(io_out_valid), pl(1));
    io_redirect_bits = pl(32'hB);
    tick();
    chk("redir_B", io_out_bits, pl(32'hB));
    io_redirect_bits = pl(32'hC);
    tick();
    chk("redir_C", io_out_bits, pl(32'hC));
    chk("redir_C_is_commit", PW'(io_out_is_commit), pl(0));
    io_redirect_valid = 1'b0;
    tick();
    chk("redir_idle_valid", PW'(io_out_valid), pl(0));

    // Commit only: D appears two edges after the enqueue
    io_commit_valid = 1'b1;
    io_commit_bits = pl(32'hD);
    #1 chk("commit_ready", PW'(io_commit_ready), pl(1));
    tick();
    io_commit_valid = 1'b0;
    chk("commit_lat1_valid", PW'(io_out_valid), pl(0));
    tick();
    chk("commit_D_valid", PW'(io_out_valid), pl(1));
    chk("commit_D", io_out_bits, pl(32'hD));
    chk("commit_D_is_commit", PW'(io_out_is_commit), pl(1));
    tick();
    chk("commit_idle_valid", PW'(io_out_valid), pl(0));

    // Starvation: E enqueued alongside a grant that happens while the queue is empty
    io_commit_valid = 1'b1;
    io_commit_bits = pl(32'hE);
    io_redirect_valid = 1'b1;
    io_redirect_bits = pl(32'h1000);
    tick();
    io_commit_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      io_redirect_bits = pl(32'h1001 + i);
      #1 chk($sformatf("starve_rr_%0d", i), PW'(io_redirect_ready), pl(1));
      tick();
      chk($sformatf("starve_out_%0d", i), io_out_bits, pl(32'h1001 + i));
      chk($sformatf("starve_isc_%0d", i), PW'(io_out_is_commit), pl(0));
    end
    #1 chk("starve_forced_rr", PW'(io_redirect_ready), pl(0));
    tick();
    chk("starve_E", io_out_bits, pl(32'hE));
    chk("starve_E_is_commit", PW'(io_out_is_commit), pl(1));
    io_redirect_bits = pl(32'h2000);
    #1 chk("starve_resume_rr", PW'(io_redirect_ready), pl(1));
    tick();
    chk("starve_resume_out", io_out_bits, pl(32'h2000));
    chk("starve_resume_isc", PW'(io_out_is_commit), pl(0));
    io_redirect_valid = 1'b0;
    tick();
    chk("starve_idle_valid", PW'(io_out_valid), pl(0));

    // Backpressure: first commit reaches the output, the next four fill the queue
    io_out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      io_commit_valid = 1'b1;
      io_commit_bits = pl(32'h3000 + i);
      #1 if (io_commit_ready) accepted++;
      tick();
      if (i >= 1) chk($sformatf("bp_hold_%0d", i), io_out_bits, pl(32'h3000));
    end
    io_commit_valid = 1'b0;
    chk("bp_accepted", PW'(accepted), pl(5));
    #1 chk("bp_full_ready", PW'(io_commit_ready), pl(0));
    io_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("bp_drain_%0d", i), io_out_bits, pl(32'h3000 + i));
      chk($sformatf("bp_drain_isc_%0d", i), PW'(io_out_is_commit), pl(1));
    end
    tick();
    chk("bp_drained_valid", PW'(io_out_valid), pl(0));

    // Flush: F in the output, three queued, flush with a concurrent commit offer
    io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      io_commit_valid = 1'b1;
      io_commit_bits = (i == 0) ? pl(32'hF) : pl(32'h4000 + i);
      tick();
    end
    io_commit_flush = 1'b1;
    io_commit_bits = pl(32'h4004);
    #1 chk("flush_commit_ready", PW'(io_commit_ready), pl(0));
    tick();
    io_commit_flush = 1'b0;
    io_commit_valid = 1'b0;
    chk("flush_F_held", io_out_bits, pl(32'hF));
    chk("flush_F_valid", PW'(io_out_valid), pl(1));
    #1 chk("flush_ready_after", PW'(io_commit_ready), pl(1));
    io_out_ready = 1'b1;
    tick();
    chk("flush_empty_1", PW'(io_out_valid), pl(0));
    tick();
    chk("flush_empty_2", PW'(io_out_valid), pl(0));

    // Asynchronous reset with an update pending in the output and one queued
    io_out_ready = 1'b0;
    io_redirect_valid = 1'b1;
    io_redirect_bits = pl(32'h5000);
    io_commit_valid = 1'b1;
    io_commit_bits = pl(32'h5001);
    tick();
    io_redirect_valid = 1'b0;
    io_commit_valid = 1'b0;
    chk("ar_pre_valid", PW'(io_out_valid), pl(1));
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", PW'(io_out_valid), pl(0));
    chk("ar_bits", io_out_bits, pl(0));
    #1 reset = 1'b0;
    tick();
    io_out_ready = 1'b1;
    io_redirect_valid = 1'b1;
    io_redirect_bits = pl(32'h6000);
    tick();
    io_redirect_valid = 1'b0;
    chk("ar_post_redirect", io_out_bits, pl(32'h6000));
    chk("ar_post_isc", PW'(io_out_is_commit), pl(0));
    tick();
    chk("ar_queue_empty", PW'(io_out_valid), pl(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
